// File: rtl/pwm_ramp_ctrl.sv
// ---------------------------------------------------------------------------
// pwm_ramp_ctrl
//   Soft-start / soft-stop controller for a downstream PWM generator. A
//   command sets the PWM period and a target duty; the duty is then walked
//   toward the target by a fixed step every `interval` clocks, held there,
//   and walked back to zero when enable drops. An emergency stop kills the
//   PWM output on the next clock.
//
// Ports
//   clk, n_rst      clock (rising edge) and asynchronous active-low reset
//   enable          1 = run, 0 = ramp down to off
//   estop           emergency stop, sampled synchronously
//   cmd_valid       a command is offered
//   cmd_ready       command accepted on a clock where cmd_valid && cmd_ready
//   cmd_size        PWM period in clocks
//   cmd_duty        target high time in clocks
//   cmd_step        duty increment per step (0 behaves as 1)
//   cmd_interval    clocks between steps (0 behaves as 1)
//   SIZE            period to the PWM generator
//   DUTY_CYCLE      duty to the PWM generator
//   valid           PWM output enable (RAMP, HOLD, DOWN)
//   busy            high in RAMP and DOWN
//   at_target       high in HOLD
// ---------------------------------------------------------------------------
module pwm_ramp_ctrl #(
    parameter int unsigned W  = 20,
    parameter int unsigned IW = 16
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          enable,
    input  logic          estop,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [W-1:0]  cmd_size,
    input  logic [W-1:0]  cmd_duty,
    input  logic [W-1:0]  cmd_step,
    input  logic [IW-1:0] cmd_interval,
    output logic [W-1:0]  SIZE,
    output logic [W-1:0]  DUTY_CYCLE,
    output logic          valid,
    output logic          busy,
    output logic          at_target
);

    // One extra bit so step arithmetic can never wrap.
    localparam int unsigned WX = W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_HOLD = 2'd2,
        ST_DOWN = 2'd3
    } state_e;

    state_e          state_q,     state_d;
    logic [W-1:0]    size_q,      size_d;
    logic [W-1:0]    duty_q,      duty_d;
    logic [W-1:0]    target_q,    target_d;
    logic [W-1:0]    step_q,      step_d;
    logic [IW-1:0]   intv_q,      intv_d;
    logic [IW-1:0]   cnt_q,       cnt_d;
    logic            valid_q,     valid_d;
    logic            busy_q,      busy_d;
    logic            at_target_q, at_target_d;
    logic            cmd_ready_q, cmd_ready_d;

    logic            accept_c;
    logic            at_goal_c;
    logic            step_tick_c;
    logic            drop_c;
    logic [W-1:0]    stepped_duty_c;
    logic [WX-1:0]   duty_x_c;
    logic [WX-1:0]   target_x_c;
    logic [WX-1:0]   step_x_c;
    logic [WX-1:0]   gap_c;

    // Handshake qualifiers; estop and enable-low outrank a command.
    assign accept_c    = cmd_valid && cmd_ready_q && enable && !estop;
    assign at_goal_c   = (duty_q == target_q);
    assign step_tick_c = (cnt_q == (intv_q - IW'(1)));
    assign drop_c      = !enable && ((state_q == ST_RAMP) || (state_q == ST_HOLD));

    // One saturating step of duty toward target, computed wide.
    always_comb begin
        duty_x_c       = {1'b0, duty_q};
        target_x_c     = {1'b0, target_q};
        step_x_c       = {1'b0, step_q};
        gap_c          = '0;
        stepped_duty_c = duty_q;
        if (duty_q < target_q) begin
            gap_c = target_x_c - duty_x_c;
            stepped_duty_c = (gap_c <= step_x_c) ? target_q : W'(duty_x_c + step_x_c);
        end else if (duty_q > target_q) begin
            gap_c = duty_x_c - target_x_c;
            stepped_duty_c = (gap_c <= step_x_c) ? target_q : W'(duty_x_c - step_x_c);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (estop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_c) state_d = ST_RAMP;
                end
                ST_RAMP: begin
                    if (!enable)        state_d = ST_DOWN;
                    else if (at_goal_c) state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    if (!enable)       state_d = ST_DOWN;
                    else if (accept_c) state_d = ST_RAMP;
                end
                ST_DOWN: begin
                    if (duty_q == '0) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output and datapath next values.
    always_comb begin
        size_d      = size_q;
        duty_d      = duty_q;
        target_d    = target_q;
        step_d      = step_q;
        intv_d      = intv_q;
        cnt_d       = cnt_q;
        valid_d     = (state_d != ST_IDLE);
        busy_d      = (state_d == ST_RAMP) || (state_d == ST_DOWN);
        at_target_d = (state_d == ST_HOLD);
        cmd_ready_d = ((state_d == ST_IDLE) || (state_d == ST_HOLD)) && enable && !estop;

        if (estop) begin
            duty_d = '0;
            cnt_d  = '0;
        end else if (drop_c) begin
            // Ramp down keeps the latched step and interval cadence.
            target_d = '0;
            cnt_d    = '0;
        end else if (accept_c) begin
            size_d   = cmd_size;
            duty_d   = (duty_q < cmd_size) ? duty_q : cmd_size;
            target_d = (cmd_duty < cmd_size) ? cmd_duty : cmd_size;
            step_d   = (cmd_step == '0) ? W'(1) : cmd_step;
            intv_d   = (cmd_interval == '0) ? IW'(1) : cmd_interval;
            cnt_d    = '0;
        end else if ((state_q == ST_RAMP) || (state_q == ST_DOWN)) begin
            if (at_goal_c) begin
                cnt_d = '0;
            end else if (step_tick_c) begin
                cnt_d  = '0;
                duty_d = stepped_duty_c;
            end else begin
                cnt_d = cnt_q + IW'(1);
            end
        end
    end

    // Registered outputs and datapath.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            size_q      <= '0;
            duty_q      <= '0;
            target_q    <= '0;
            step_q      <= '0;
            intv_q      <= '0;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            at_target_q <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            size_q      <= size_d;
            duty_q      <= duty_d;
            target_q    <= target_d;
            step_q      <= step_d;
            intv_q      <= intv_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            at_target_q <= at_target_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign SIZE       = size_q;
    assign DUTY_CYCLE = duty_q;
    assign valid      = valid_q;
    assign busy       = busy_q;
    assign at_target  = at_target_q;
    assign cmd_ready  = cmd_ready_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pwm_ramp_ctrl
//   Directed bench for pwm_ramp_ctrl with hand-computed expected values.
//   Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_pwm_ramp_ctrl;

    localparam int unsigned W  = 20;
    localparam int unsigned IW = 16;

    logic          clk;
    logic          n_rst;
    logic          enable;
    logic          estop;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [W-1:0]  cmd_size;
    logic [W-1:0]  cmd_duty;
    logic [W-1:0]  cmd_step;
    logic [IW-1:0] cmd_interval;
    logic [W-1:0]  SIZE;
    logic [W-1:0]  DUTY_CYCLE;
    logic          valid;
    logic          busy;
    logic          at_target;

    int n_cmp;
    int n_bad;

    pwm_ramp_ctrl #(.W(W), .IW(IW)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .enable       (enable),
        .estop        (estop),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_size     (cmd_size),
        .cmd_duty     (cmd_duty),
        .cmd_step     (cmd_step),
        .cmd_interval (cmd_interval),
        .SIZE         (SIZE),
        .DUTY_CYCLE   (DUTY_CYCLE),
        .valid        (valid),
        .busy         (busy),
        .at_target    (at_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Offer one command for exactly one clock; ready must already be high.
    task automatic send(input int size, input int duty, input int step, input int intv);
        check_eq("ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_size     = W'(size);
        cmd_duty     = W'(duty);
        cmd_step     = W'(step);
        cmd_interval = IW'(intv);
        cmd_valid    = 1'b1;
        tick();
        cmd_valid    = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_size"},  32'(SIZE),       32'd0);
        check_eq({tag, "_duty"},  32'(DUTY_CYCLE), 32'd0);
        check_eq({tag, "_valid"}, 32'(valid),      32'd0);
        check_eq({tag, "_busy"},  32'(busy),       32'd0);
        check_eq({tag, "_attgt"}, 32'(at_target),  32'd0);
        check_eq({tag, "_ready"}, 32'(cmd_ready),  32'd0);
    endtask

    initial begin
        int exp_dn [3];
        int prev;

        n_cmp        = 0;
        n_bad        = 0;
        enable       = 1'b1;
        estop        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_size     = '0;
        cmd_duty     = '0;
        cmd_step     = '0;
        cmd_interval = '0;
        n_rst        = 1'b1;
        #1 n_rst     = 1'b0;

        // Reset state, then ready rises on the first enabled edge.
        repeat (2) @(negedge clk);
        check_all_zero("rst");
        n_rst = 1'b1;
        check_eq("ready_no_edge", 32'(cmd_ready), 32'd0);
        tick();
        check_eq("ready_first_edge", 32'(cmd_ready), 32'd1);

        // Ramp 0 -> 500 in steps of 100 every 4 clocks.
        send(1000, 500, 100, 4);
        check_eq("s1_size",  32'(SIZE),       32'd1000);
        check_eq("s1_duty0", 32'(DUTY_CYCLE), 32'd0);
        check_eq("s1_valid", 32'(valid),      32'd1);
        check_eq("s1_busy",  32'(busy),       32'd1);
        check_eq("s1_ready", 32'(cmd_ready),  32'd0);
        for (int s = 1; s <= 5; s++) begin
            repeat (3) tick();
            check_eq("s1_pre_step", 32'(DUTY_CYCLE), 32'(100 * (s - 1)));
            tick();
            check_eq("s1_step", 32'(DUTY_CYCLE), 32'(100 * s));
        end
        check_eq("s1_not_yet_hold", 32'(at_target), 32'd0);
        tick();
        check_eq("s1_hold",       32'(at_target), 32'd1);
        check_eq("s1_hold_busy",  32'(busy),      32'd0);
        check_eq("s1_hold_valid", 32'(valid),     32'd1);

        // From HOLD at 500 ramp down to 100 in steps of 150.
        send(1000, 100, 150, 2);
        check_eq("s2_size", 32'(SIZE),       32'd1000);
        check_eq("s2_duty", 32'(DUTY_CYCLE), 32'd500);
        exp_dn = '{350, 200, 100};
        prev   = 500;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("s2_pre_step", 32'(DUTY_CYCLE), 32'(prev));
            tick();
            check_eq("s2_step", 32'(DUTY_CYCLE), 32'(exp_dn[i]));
            prev = exp_dn[i];
        end
        tick();
        check_eq("s2_hold", 32'(at_target), 32'd1);

        // Back up to 500 (step 200), then enable low ramps down to off.
        send(1000, 500, 200, 1);
        tick();
        check_eq("s3_up1", 32'(DUTY_CYCLE), 32'd300);
        tick();
        check_eq("s3_up2", 32'(DUTY_CYCLE), 32'd500);
        tick();
        check_eq("s3_hold", 32'(at_target), 32'd1);
        enable = 1'b0;
        tick();
        check_eq("s3_down_busy",  32'(busy),       32'd1);
        check_eq("s3_down_attgt", 32'(at_target),  32'd0);
        check_eq("s3_down_duty",  32'(DUTY_CYCLE), 32'd500);
        tick();
        check_eq("s3_dn1", 32'(DUTY_CYCLE), 32'd300);
        enable       = 1'b1;
        cmd_size     = W'(777);
        cmd_duty     = W'(50);
        cmd_valid    = 1'b1;
        tick();
        check_eq("s3_dn2",        32'(DUTY_CYCLE), 32'd100);
        check_eq("s3_no_resume",  32'(cmd_ready),  32'd0);
        tick();
        check_eq("s3_dn3",        32'(DUTY_CYCLE), 32'd0);
        check_eq("s3_valid_at0",  32'(valid),      32'd1);
        cmd_valid = 1'b0;
        tick();
        check_eq("s3_idle_valid", 32'(valid),     32'd0);
        check_eq("s3_idle_busy",  32'(busy),      32'd0);
        check_eq("s3_idle_size",  32'(SIZE),      32'd1000);
        check_eq("s3_idle_ready", 32'(cmd_ready), 32'd1);

        // No overshoot: 100, 200, 250.
        send(1000, 250, 100, 1);
        check_eq("s4_duty0", 32'(DUTY_CYCLE), 32'd0);
        tick();
        check_eq("s4_a", 32'(DUTY_CYCLE), 32'd100);
        tick();
        check_eq("s4_b", 32'(DUTY_CYCLE), 32'd200);
        tick();
        check_eq("s4_c", 32'(DUTY_CYCLE), 32'd250);
        tick();
        check_eq("s4_hold", 32'(at_target), 32'd1);

        // Target above period clamps to the period.
        send(1000, 2000, 400, 1);
        tick();
        check_eq("s4_clamp_a", 32'(DUTY_CYCLE), 32'd650);
        tick();
        check_eq("s4_clamp_b", 32'(DUTY_CYCLE), 32'd1000);
        tick();
        check_eq("s4_clamp_hold", 32'(at_target), 32'd1);

        // Shrinking the period clamps duty at accept; RAMP lasts one clock.
        send(600, 800, 10, 5);
        check_eq("s4_shrink_size", 32'(SIZE),       32'd600);
        check_eq("s4_shrink_duty", 32'(DUTY_CYCLE), 32'd600);
        check_eq("s4_shrink_busy", 32'(busy),       32'd1);
        tick();
        check_eq("s4_shrink_hold", 32'(at_target), 32'd1);

        // estop mid-RAMP beats enable low and a pending command.
        send(600, 0, 100, 3);
        tick();
        tick();
        check_eq("s5_mid_duty", 32'(DUTY_CYCLE), 32'd600);
        check_eq("s5_mid_busy", 32'(busy),       32'd1);
        estop     = 1'b1;
        enable    = 1'b0;
        cmd_size  = W'(500);
        cmd_duty  = W'(300);
        cmd_valid = 1'b1;
        tick();
        check_eq("s5_duty",  32'(DUTY_CYCLE), 32'd0);
        check_eq("s5_valid", 32'(valid),      32'd0);
        check_eq("s5_busy",  32'(busy),       32'd0);
        check_eq("s5_attgt", 32'(at_target),  32'd0);
        check_eq("s5_size",  32'(SIZE),       32'd600);
        enable = 1'b1;
        repeat (2) tick();
        check_eq("s5_held_ready", 32'(cmd_ready), 32'd0);
        check_eq("s5_held_valid", 32'(valid),     32'd0);
        check_eq("s5_held_size",  32'(SIZE),      32'd600);
        estop     = 1'b0;
        cmd_valid = 1'b0;
        tick();
        check_eq("s5_release_ready", 32'(cmd_ready), 32'd1);

        // step 0 / interval 0 behave as 1 / 1, then async reset mid-ramp.
        send(100, 50, 0, 0);
        check_eq("s6_size", 32'(SIZE), 32'd100);
        tick();
        check_eq("s6_a", 32'(DUTY_CYCLE), 32'd1);
        tick();
        check_eq("s6_b", 32'(DUTY_CYCLE), 32'd2);
        tick();
        check_eq("s6_c", 32'(DUTY_CYCLE), 32'd3);
        @(posedge clk);
        #2 n_rst = 1'b0;
        #1 check_all_zero("arst");
        @(negedge clk);
        n_rst = 1'b1;
        tick();
        check_eq("arst_ready", 32'(cmd_ready), 32'd1);

        // Duty already at target on accept: one clock of RAMP.
        send(100, 0, 5, 3);
        check_eq("s7_busy",  32'(busy),      32'd1);
        check_eq("s7_attgt", 32'(at_target), 32'd0);
        tick();
        check_eq("s7_hold",      32'(at_target), 32'd1);
        check_eq("s7_hold_busy", 32'(busy),      32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 SHALL have parameter W, default 20, giving the width of the period and duty values.
REQ-002 SHALL have parameter IW, default 16, giving the width of the step-interval counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port n_rst, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port enable, input, 1; high = run, low = ramp down to off.
REQ-006 SHALL have port estop, input, 1; emergency stop, sampled synchronously.
REQ-007 SHALL have port cmd_valid, input, 1; a command is offered.
REQ-008 SHALL have port cmd_ready, output, 1; the command is accepted on the clock where cmd_valid && cmd_ready.
REQ-009 SHALL have port cmd_size, input, W; PWM period in clocks.
REQ-010 SHALL have port cmd_duty, input, W; target high time in clocks.
REQ-011 SHALL have port cmd_step, input, W; duty increment per step.
REQ-012 SHALL have port cmd_interval, input, IW; clocks between steps.
REQ-013 SHALL have port SIZE, output, W; period to the downstream PWM generator.
REQ-014 SHALL have port DUTY_CYCLE, output, W; duty to the downstream PWM generator.
REQ-015 SHALL have port valid, output, 1; PWM output enable to the downstream generator.
REQ-016 SHALL have port busy, output, 1; high in the RAMP and DOWN states.
REQ-017 SHALL have port at_target, output, 1; high in the HOLD state.

Function
REQ-018 SHALL implement states IDLE, RAMP, HOLD and DOWN; all outputs are registered.
REQ-019 SHALL drive cmd_ready = (IDLE or HOLD) && enable && !estop.
REQ-020 SHALL, on command accept, latch step (0 treated as 1), interval (0 treated as 1) and target = min(cmd_duty, cmd_size).
REQ-021 SHALL, on command accept, load SIZE = cmd_size on the next clock, clamp DUTY_CYCLE to min(DUTY_CYCLE, cmd_size), clear the interval counter, and enter RAMP.
REQ-022 SHALL update SIZE only on command accept.
REQ-023 SHALL, in RAMP, increment the interval counter each clock; when it reaches interval-1, clear it and move DUTY_CYCLE one step toward target.
REQ-024 SHALL saturate each step at target with no overshoot, computing in W+1 bits with no wrap in either direction.
REQ-025 SHALL enter HOLD on the clock after DUTY_CYCLE == target; if DUTY_CYCLE already equals target at accept, RAMP lasts exactly one clock.
REQ-026 SHALL, in HOLD, hold all outputs; a new command re-enters RAMP from the current DUTY_CYCLE, up or down.
REQ-027 SHALL drive valid = 1 in RAMP, HOLD and DOWN, and 0 in IDLE.
REQ-028 SHALL, when enable is low in RAMP or HOLD, enter DOWN with target = 0 and keep the latched step and interval.
REQ-029 SHALL, in DOWN, step DUTY_CYCLE toward 0 at the same cadence; when it reaches 0, go to IDLE next clock and clear valid there.
REQ-030 SHALL leave SIZE unchanged in DOWN and IDLE.
REQ-031 SHALL NOT resume from DOWN when enable returns high; a new command is accepted only after IDLE.
REQ-032 SHALL, when estop is high, on the next clock force DUTY_CYCLE = 0, valid = 0, busy = 0, at_target = 0, clear the interval counter and enter IDLE.
REQ-033 SHALL hold IDLE for as long as estop is high.
REQ-034 SHALL apply priority estop > enable low > command accept > step.
REQ-035 SHALL give latency: accept at clock N; SIZE, clamped DUTY_CYCLE and valid updated at N+1; first step at N+interval.

Reset
REQ-036 SHALL, while n_rst is low, force SIZE = 0, DUTY_CYCLE = 0, valid = 0, busy = 0, at_target = 0, cmd_ready = 0, interval counter = 0, latched registers = 0, state IDLE.
REQ-037 SHALL apply REQ-036 asynchronously, including mid-ramp.
REQ-038 SHALL, after reset release, drive cmd_ready = 1 on the first clock edge at which enable = 1 and estop = 0.

Verification
REQ-039 SHALL cover: size = 1000, duty = 500, step = 100, interval = 4 -> DUTY_CYCLE steps 0, 100, ..., 500 every 4 clocks; HOLD and at_target = 1 after the 5th step; valid high from N+1.
REQ-040 SHALL cover: duty = 250, step = 100 -> sequence 100, 200, 250 with no overshoot; duty = 2000, size = 1000 -> target clamped to 1000.
REQ-041 SHALL cover: HOLD at 500, then command duty = 100, step = 150 -> sequence 350, 200, 100, HOLD; SIZE unchanged if cmd_size is equal.
REQ-042 SHALL cover: enable dropped in HOLD at 500, step = 200 -> DOWN 300, 100, 0, IDLE; valid falls one clock after 0 is reached; enable re-raised mid-DOWN -> no resume.
REQ-043 SHALL cover: estop pulsed mid-RAMP together with cmd_valid and enable low -> next clock DUTY_CYCLE = 0, valid = 0, IDLE; command not accepted.
REQ-044 SHALL cover: n_rst asserted mid-RAMP between clock edges -> all outputs 0 immediately; step = 0 and interval = 0 commands behave as 1 and 1.
